// File: rtl/mem_responder.sv
// Unified word memory responder with fixed access latency and ready pulse.
// Requests are captured in IDLE; WAIT counts down; RESP pulses ready.
module mem_responder #(
    parameter int    DEPTH_WORDS = 64,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      count;
    logic [3:0]      count_next;
    logic [AW-1:0]   idx;
    logic [31:0]     wdata;
    logic            op_write;
    logic            accept;
    logic            load_rd;
    logic [AW-1:0]   rd_idx;
    logic            unused;
    logic [31:0]     mem [DEPTH_WORDS];

    // Address bits above the word index wrap silently.
    assign unused = ^adr[31:AW+2];

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (memread || memwrite) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (count <= 4'd1) begin
                    state_next = RESP;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY=1 the read goes straight from IDLE, so use live inputs.
    assign rd_idx  = accept ? adr[AW+1:2] : idx;
    assign load_rd = (state_next == RESP) && (state != RESP)
                     && !(accept ? memwrite : op_write);

    assign ready = (state == RESP);
    assign busy  = (state == WAIT) || (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            idx      <= '0;
            wdata    <= 32'd0;
            op_write <= 1'b0;
            rd       <= 32'd0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                idx      <= adr[AW+1:2];
                wdata    <= wd;
                op_write <= memwrite;
                if ((memread && memwrite) || (adr[1:0] != 2'b00)) begin
                    err <= 1'b1;
                end
            end
            if (load_rd) begin
                rd <= mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == RESP && op_write) begin
            mem[idx] <= wdata;
        end
    end
endmodule
